// File: rtl/mips_dmem_responder.sv
// Data-memory responder for the MIPS core: a single-outstanding valid/ready slave
// with programmable wait states in front of a byte-enabled 32-bit word array.
module mips_dmem_responder #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_nextState;
  logic [3:0]            r_count;
  logic                  r_we;
  logic [31:0]           r_addr;
  logic [31:0]           r_wdata;
  logic [3:0]            r_be;
  logic [31:0]           r_rdata;
  logic                  r_err;
  logic [31:0]           r_mem [DEPTH];

  logic                  w_access;
  logic                  w_err;
  logic                  w_wrEn;
  logic [DEPTH_LOG2-1:0] w_index;

  // The access happens on the edge where the wait counter has run out.
  assign w_access = (r_state == WAIT) && (r_count == 4'd0);
  assign w_err    = (r_addr[1:0] != 2'b00) || ((r_addr >> (DEPTH_LOG2 + 2)) != 32'd0);
  assign w_wrEn   = w_access && r_we && !w_err;
  assign w_index  = r_addr[DEPTH_LOG2+1:2];

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = (r_state == RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (req_valid) w_nextState = WAIT;
      WAIT:    if (r_count == 4'd0) w_nextState = RESP;
      RESP:    if (rsp_ready) w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state <= IDLE;
      r_count <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_be    <= req_be;
            r_count <= 4'(WAIT_CYCLES);
          end
        end
        WAIT: begin
          if (r_count != 4'd0) begin
            r_count <= r_count - 4'd1;
          end else begin
            r_err   <= w_err;
            r_rdata <= (!w_err && !r_we) ? r_mem[w_index] : 32'd0;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_rdata <= 32'd0;
            r_err   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  // Array has no reset; a reset during WAIT leaves r_state in IDLE so w_wrEn stays low.
  always_ff @(posedge clk) begin
    if (w_wrEn) begin
      for (int i = 0; i < 4; i++) begin
        if (r_be[i]) r_mem[w_index][8*i +: 8] <= r_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Scoreboard bench for mips_dmem_responder: three instances (2, 0 and 15 wait states)
// share one clock/reset; stimulus pushes expected responses, a monitor pops and compares.
`timescale 1ns/1ps
module tb_mips_dmem_responder;

  localparam int W0 = 2;
  localparam int W1 = 0;
  localparam int W2 = 15;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acceptCycle;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        reqValid  [3];
  logic        reqReady  [3];
  logic        reqWe     [3];
  logic [31:0] reqAddr   [3];
  logic [31:0] reqWdata  [3];
  logic [3:0]  reqBe     [3];
  logic        rspValid  [3];
  logic        rspReady  [3];
  logic [31:0] rspRdata  [3];
  logic        rspErr    [3];

  exp_t expQ     [3][$];
  exp_t lastExp  [3];
  exp_t popped;
  logic prevValid [3];

  int cycleCount  = 0;
  int testsRun    = 0;
  int testsFailed = 0;

  always #5 clk = ~clk;

  mips_dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W0)) dut0 (
    .clk(clk), .clr(clr),
    .req_valid(reqValid[0]), .req_ready(reqReady[0]), .req_we(reqWe[0]),
    .req_addr(reqAddr[0]), .req_wdata(reqWdata[0]), .req_be(reqBe[0]),
    .rsp_valid(rspValid[0]), .rsp_ready(rspReady[0]),
    .rsp_rdata(rspRdata[0]), .rsp_err(rspErr[0])
  );

  mips_dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W1)) dut1 (
    .clk(clk), .clr(clr),
    .req_valid(reqValid[1]), .req_ready(reqReady[1]), .req_we(reqWe[1]),
    .req_addr(reqAddr[1]), .req_wdata(reqWdata[1]), .req_be(reqBe[1]),
    .rsp_valid(rspValid[1]), .rsp_ready(rspReady[1]),
    .rsp_rdata(rspRdata[1]), .rsp_err(rspErr[1])
  );

  mips_dmem_responder #(.DEPTH_LOG2(8), .WAIT_CYCLES(W2)) dut2 (
    .clk(clk), .clr(clr),
    .req_valid(reqValid[2]), .req_ready(reqReady[2]), .req_we(reqWe[2]),
    .req_addr(reqAddr[2]), .req_wdata(reqWdata[2]), .req_be(reqBe[2]),
    .rsp_valid(rspValid[2]), .rsp_ready(rspReady[2]),
    .rsp_rdata(rspRdata[2]), .rsp_err(rspErr[2])
  );

  function automatic int latencyOf(input int d);
    case (d)
      0:       return W0 + 1;
      1:       return W1 + 1;
      default: return W2 + 1;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Monitor: each new response is matched against the head of that instance's queue;
  // while a response is held under backpressure it must keep matching the same entry.
  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (rspValid[d] && !prevValid[d]) begin
        if (expQ[d].size() == 0) begin
          testsRun++;
          testsFailed++;
          $display("[TB] FAIL unexpected_rsp dut%0d: got rsp_valid=1, required no response", d);
        end else begin
          popped = expQ[d].pop_front();
          lastExp[d] = popped;
          checkOutput($sformatf("rdata dut%0d", d), rspRdata[d], popped.rdata);
          checkOutput($sformatf("err dut%0d", d), {31'd0, rspErr[d]}, {31'd0, popped.err});
          checkOutput($sformatf("latency dut%0d", d), 32'(cycleCount - popped.acceptCycle),
                      32'(latencyOf(d)));
        end
      end else if (rspValid[d] && prevValid[d]) begin
        checkOutput($sformatf("held rdata dut%0d", d), rspRdata[d], lastExp[d].rdata);
        checkOutput($sformatf("held err dut%0d", d), {31'd0, rspErr[d]}, {31'd0, lastExp[d].err});
        checkOutput($sformatf("held req_ready dut%0d", d), {31'd0, reqReady[d]}, 32'd0);
      end
      prevValid[d] = rspValid[d];
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge.
  task automatic applyStimulus(input int d, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] be,
                               input logic [31:0] expRdata, input logic expErr,
                               input bit expectRsp, output int acceptCycle);
    int   waited = 0;
    exp_t e;
    while (!reqReady[d] && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!reqReady[d]) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL req_ready_timeout dut%0d: got req_ready=0, required 1 within 100 cycles", d);
      acceptCycle = -1;
      return;
    end
    reqValid[d] = 1'b1;
    reqWe[d]    = we;
    reqAddr[d]  = addr;
    reqWdata[d] = wdata;
    reqBe[d]    = be;
    acceptCycle = cycleCount + 1;
    if (expectRsp) begin
      e.rdata       = expRdata;
      e.err         = expErr;
      e.acceptCycle = acceptCycle;
      expQ[d].push_back(e);
    end
    @(negedge clk);
    reqValid[d] = 1'b0;
  endtask

  task automatic waitDrain(input int d);
    int n = 0;
    while ((expQ[d].size() != 0 || !reqReady[d]) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (expQ[d].size() != 0 || !reqReady[d]) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL drain_timeout dut%0d: got %0d pending responses, required 0", d,
               expQ[d].size());
      expQ[d].delete();
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int acc;
    int acc2;
    int acc3;
    int n;

    for (int d = 0; d < 3; d++) begin
      reqValid[d]  = 1'b0;
      reqWe[d]     = 1'b0;
      reqAddr[d]   = 32'd0;
      reqWdata[d]  = 32'd0;
      reqBe[d]     = 4'd0;
      rspReady[d]  = 1'b1;
      prevValid[d] = 1'b0;
    end
    clr = 1'b0;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset req_ready dut%0d", d), {31'd0, reqReady[d]}, 32'd1);
      checkOutput($sformatf("reset rsp_valid dut%0d", d), {31'd0, rspValid[d]}, 32'd0);
      checkOutput($sformatf("reset rsp_rdata dut%0d", d), rspRdata[d], 32'd0);
      checkOutput($sformatf("reset rsp_err dut%0d", d), {31'd0, rspErr[d]}, 32'd0);
    end
    clr = 1'b1;
    @(negedge clk);

    // Full-word store then load back
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, acc);

    // Byte lanes 0 and 2 only, then an all-lanes-off store
    applyStimulus(0, 1'b1, 32'h20, 32'h11223344, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b0, 32'h20, 32'h0, 4'h0, 32'h11BB33DD, 1'b0, 1'b1, acc);

    // Misaligned load and out-of-range store must not touch word 0
    applyStimulus(0, 1'b1, 32'h0, 32'h0BADF00D, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    applyStimulus(0, 1'b0, 32'h22, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1, acc);
    applyStimulus(0, 1'b1, 32'h400, 32'hFFFFFFFF, 4'hF, 32'h0, 1'b1, 1'b1, acc);
    applyStimulus(0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0BADF00D, 1'b0, 1'b1, acc);
    waitDrain(0);

    // Backpressure: hold the response for 5 cycles while poking req_valid
    rspReady[0] = 1'b0;
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, acc);
    n = 0;
    while (!rspValid[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("bp rsp_valid seen", {31'd0, rspValid[0]}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      checkOutput("bp req_ready", {31'd0, reqReady[0]}, 32'd0);
      reqValid[0] = 1'b1;
      reqWe[0]    = 1'b1;
      reqAddr[0]  = 32'h10;
      reqWdata[0] = 32'h0;
      reqBe[0]    = 4'hF;
      @(negedge clk);
    end
    reqValid[0] = 1'b0;
    rspReady[0] = 1'b1;
    @(negedge clk);
    checkOutput("bp after rsp_valid", {31'd0, rspValid[0]}, 32'd0);
    checkOutput("bp after req_ready", {31'd0, reqReady[0]}, 32'd1);
    checkOutput("bp after rsp_rdata", rspRdata[0], 32'd0);
    checkOutput("bp after rsp_err", {31'd0, rspErr[0]}, 32'd0);
    applyStimulus(0, 1'b0, 32'h10, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0, 1'b1, acc);
    waitDrain(0);

    // Reset one cycle into WAIT discards the store
    applyStimulus(0, 1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 32'h0, 1'b0, 1'b1, acc);
    waitDrain(0);
    applyStimulus(0, 1'b1, 32'h30, 32'h12345678, 4'hF, 32'h0, 1'b0, 1'b0, acc);
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    for (int i = 0; i < 20; i++) @(negedge clk);
    checkOutput("midreset rsp_valid", {31'd0, rspValid[0]}, 32'd0);
    applyStimulus(0, 1'b0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D, 1'b0, 1'b1, acc);
    waitDrain(0);

    // Latency and back-to-back throughput at 0 and 15 wait states
    for (int d = 1; d < 3; d++) begin
      applyStimulus(d, 1'b1, 32'h40, 32'h5A5A5A5A, 4'hF, 32'h0, 1'b0, 1'b1, acc);
      applyStimulus(d, 1'b0, 32'h40, 32'h0, 4'h0, 32'h5A5A5A5A, 1'b0, 1'b1, acc2);
      applyStimulus(d, 1'b1, 32'h44, 32'h01020304, 4'hF, 32'h0, 1'b0, 1'b1, acc3);
      checkOutput($sformatf("throughput1 dut%0d", d), 32'(acc2 - acc), 32'(latencyOf(d) + 2));
      checkOutput($sformatf("throughput2 dut%0d", d), 32'(acc3 - acc2), 32'(latencyOf(d) + 2));
      waitDrain(d);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
